text_typewriter_ctrl: RTL
=========================

# text_typewriter_ctrl

Sequencer that drives the menu letter-array datapath with a typewriter effect. On `start` it snapshots a NUM_LETTERS-entry array of 5-bit letter codes, then reveals them left to right, one letter every FRAMES_PER_LETTER video frames. A blinking cursor glyph marks the next position. The block sits between the game-menu FSM, which supplies the text and start/skip, and the letter-array renderer, which consumes `letters_out`.

## Interface
- NUM_LETTERS, 10, number of letter slots (1..16)
- FRAMES_PER_LETTER, 8, startOfFrame pulses per revealed letter (>=1)
- BLINK_FRAMES, 16, startOfFrame pulses per cursor toggle (>=1)

- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- startOfFrame  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse: latch `letters_in`, begin reveal
- skip  in  1  one-cycle pulse: reveal all remaining letters immediately
- letters_in  in  5 x NUM_LETTERS  source text, sampled only on accepted `start`
- letters_out  out  5 x NUM_LETTERS  text to renderer (registered)
- busy  out  1  high while revealing
- done  out  1  one-cycle pulse when the full text becomes visible
- reveal_count  out  $clog2(NUM_LETTERS+1)  letters currently revealed

## Operation
- States:
  - IDLE: nothing shown
  - REVEAL: letters appearing
  - SHOWN: full text held
- Reset: state IDLE; all `letters_out` = BLANK_CODE; busy=0; done=0; reveal_count=0; frame/blink counters 0; cursor_on=1.
- IDLE: on `start`, snapshot `letters_in` → text_reg, reveal_count=0, frame_cnt=0, blink_cnt=0, cursor_on=1, go to REVEAL.
- REVEAL, on each startOfFrame:
  - frame_cnt advances. When it equals FRAMES_PER_LETTER-1: frame_cnt←0, reveal_count+1, cursor_on←1, blink_cnt←0.
  - Otherwise blink_cnt advances. When it equals BLINK_FRAMES-1: blink_cnt←0, toggle cursor_on.
- REVEAL → SHOWN when reveal_count increments to NUM_LETTERS. `done` pulses in that transition cycle +1. busy drops together with the done pulse.
- `skip` in REVEAL: reveal_count←NUM_LETTERS, go to SHOWN, `done` pulses. Ignored in IDLE and SHOWN.
- SHOWN: holds text indefinitely. `start` restarts from REVEAL with a fresh snapshot.
- `start` is accepted in every state, including mid-REVEAL. It restarts with no `done` pulse for the aborted text.
- `start` and `skip` in the same cycle: `start` wins, and skip is dropped.
- `start` coinciding with startOfFrame: the start takes effect, and that frame pulse is not counted.
- `letters_out[i]` is computed from registered state:
  - i < reveal_count: text_reg[i]
  - i == reveal_count and state==REVEAL: CURSOR_CODE if cursor_on, else BLANK_CODE
  - otherwise: BLANK_CODE
- Changes to `letters_in` after `start` have no effect.

## Timing
- `start` at cycle t:
  - state=REVEAL and busy=1 at t+1
  - `letters_out` shows cursor at slot 0, rest blank, at t+1
- `letters_out`, `busy`, `reveal_count` and `done` are all registered and updated together with the state. No combinational path from inputs to outputs.
- Letter k (0-based) appears the cycle after the (k+1)·FRAMES_PER_LETTER-th startOfFrame following `start`.
- Full reveal with no skip takes NUM_LETTERS·FRAMES_PER_LETTER frames. done=1 for exactly one cycle.
- `skip` at cycle t: all letters visible, busy=0 and done=1 at t+1.
- Reset asserted mid-REVEAL: outputs return to reset values at the next edge. No done pulse.

## Structure
- Package `menu_text_pkg`:
  - letter code constants BLANK_CODE=5'd0 and CURSOR_CODE=5'd31
  - `letter_t` typedef (logic [4:0])
  - state enum {IDLE, REVEAL, SHOWN}
- Sub-module `frame_tick_div`: counts startOfFrame pulses up to a parameterised terminal value, with a synchronous clear. It emits a one-cycle tick at terminal. Instantiated twice: letter pacing and blink pacing.
- Top holds the FSM, the snapshot register array, and the output mux.

## Test plan
- Reset then idle 20 frames → all `letters_out`=0, busy=0, done never asserted.
- FRAMES_PER_LETTER=2, BLINK_FRAMES=1, `letters_in`=1..10, `start` → slot 0 alternates 31/0 each frame. Slot 0=1 after frame 2. Slot k=k+1 after frame 2(k+1). done pulses once after frame 20, and reveal_count=10.
- Same setup, `skip` after frame 5 (reveal_count=2) → next cycle all slots=1..10, done=1 for one cycle, busy=0.
- `start` mid-REVEAL with `letters_in`=5'd7 everywhere → next cycle reveal_count=0 and cursor at slot 0. No done for the first text. Subsequent letters are 7.
- `start` and `skip` same cycle in SHOWN → restart (busy=1, reveal_count=0), no done.
- Reset asserted at frame 7 of a reveal → next cycle all outputs at reset values. A following `start` behaves as from power-up.

Source files
------------

// File: rtl/menu_text_pkg.sv
// Shared types and letter codes for the menu text datapath.
// Letter code 0 renders as an empty cell and 31 renders as the cursor glyph.
package menu_text_pkg;

   typedef logic [4:0] letter_t;

   localparam letter_t BLANK_CODE  = 5'd0;
   localparam letter_t CURSOR_CODE = 5'd31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      SHOWN  = 2'd2
   } state_t;

endpackage

// File: rtl/frame_tick_div.sv
// Counts enabled frame pulses from 0 up to TERMINAL, then wraps to 0.
// o_tick is asserted in the same cycle as the enabled pulse that lands on TERMINAL.
module frame_tick_div #(
   parameter int TERMINAL = 7
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tick
);

   localparam int            W    = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1;
   localparam logic [W-1:0]  TERM = W'(TERMINAL);

   logic [W-1:0] r_cnt;

   // i_clear masks the tick, so a pulse that coincides with a clear is never counted.
   assign o_tick = i_en && !i_clear && (r_cnt == TERM);

   // Pulse counter with synchronous clear and wrap at the terminal value.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == TERM) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/text_typewriter_ctrl.sv
// Typewriter sequencer: snapshots the menu text on start and reveals it one letter
// per FRAMES_PER_LETTER frames, with a blinking cursor at the next free slot.
module text_typewriter_ctrl
   import menu_text_pkg::*;
#(
   parameter  int NUM_LETTERS       = 10,
   parameter  int FRAMES_PER_LETTER = 8,
   parameter  int BLINK_FRAMES      = 16,
   localparam int CW                = $clog2(NUM_LETTERS + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         startOfFrame,
   input  logic                         start,
   input  logic                         skip,
   input  letter_t [NUM_LETTERS-1:0]    letters_in,
   output letter_t [NUM_LETTERS-1:0]    letters_out,
   output logic                         busy,
   output logic                         done,
   output logic [CW-1:0]                reveal_count
);

   state_t                      r_state;
   letter_t [NUM_LETTERS-1:0]   r_text;
   letter_t [NUM_LETTERS-1:0]   r_letters;
   logic [CW-1:0]               r_reveal_count;
   logic                        r_cursor_on;
   logic                        r_busy;
   logic                        r_done;

   state_t                      w_state_nxt;
   letter_t [NUM_LETTERS-1:0]   w_letters_nxt;
   logic [CW-1:0]               w_count_nxt;
   logic                        w_cursor_nxt;
   logic                        w_done_nxt;
   logic                        w_sof_run;
   logic                        w_letter_tick;
   logic                        w_blink_tick;

   // A start in the same cycle as a frame pulse swallows that pulse.
   assign w_sof_run = (r_state == REVEAL) && startOfFrame && !start;

   frame_tick_div #(.TERMINAL(FRAMES_PER_LETTER - 1)) u_letter_div (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (start),
      .i_en    (w_sof_run),
      .o_tick  (w_letter_tick)
   );

   frame_tick_div #(.TERMINAL(BLINK_FRAMES - 1)) u_blink_div (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (start || w_letter_tick),
      .i_en    (w_sof_run && !w_letter_tick),
      .o_tick  (w_blink_tick)
   );

   // Next-state decode and the output mux evaluated on the next-state values.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_reveal_count;
      w_cursor_nxt = r_cursor_on;
      w_done_nxt   = 1'b0;
      if (start) begin
         w_state_nxt  = REVEAL;
         w_count_nxt  = '0;
         w_cursor_nxt = 1'b1;
      end else if (r_state == REVEAL) begin
         if (skip) begin
            w_state_nxt = SHOWN;
            w_count_nxt = CW'(NUM_LETTERS);
            w_done_nxt  = 1'b1;
         end else if (w_letter_tick) begin
            w_count_nxt  = r_reveal_count + 1'b1;
            w_cursor_nxt = 1'b1;
            if (r_reveal_count == CW'(NUM_LETTERS - 1)) begin
               w_state_nxt = SHOWN;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = REVEAL;
            end
         end else if (w_blink_tick) begin
            w_cursor_nxt = ~r_cursor_on;
         end else begin
            w_cursor_nxt = r_cursor_on;
         end
      end else begin
         w_state_nxt = r_state;
      end

      w_letters_nxt = '0;
      for (int i = 0; i < NUM_LETTERS; i++) begin
         if (CW'(i) < w_count_nxt) begin
            w_letters_nxt[i] = r_text[i];
         end else if ((CW'(i) == w_count_nxt) && (w_state_nxt == REVEAL)) begin
            w_letters_nxt[i] = w_cursor_nxt ? CURSOR_CODE : BLANK_CODE;
         end else begin
            w_letters_nxt[i] = BLANK_CODE;
         end
      end
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_text         <= '0;
         r_letters      <= '0;
         r_reveal_count <= '0;
         r_cursor_on    <= 1'b1;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_letters      <= w_letters_nxt;
         r_reveal_count <= w_count_nxt;
         r_cursor_on    <= w_cursor_nxt;
         r_busy         <= (w_state_nxt == REVEAL);
         r_done         <= w_done_nxt;
         if (start) begin
            r_text <= letters_in;
         end else begin
            r_text <= r_text;
         end
      end
   end

   assign letters_out  = r_letters;
   assign busy         = r_busy;
   assign done         = r_done;
   assign reveal_count = r_reveal_count;

endmodule
